// File: rtl/layer_sequencer.sv
// -----------------------------------------------------------------------------
// layer_sequencer
//
// Sequences a multi-layer dense (matrix-vector) job over a single processing
// unit. For every output of every layer it fetches K weight/activation beats,
// waits one cycle for the BRAM read latency to drain (TAIL), writes the result
// to the ping-pong temp buffer (WB), then clears the accumulator (CLR). That is
// K+3 cycles per output with no overlap between outputs.
//
// Ports
//   clk_i          : clock, rising edge
//   rst_i          : asynchronous, active-high reset
//   start_i        : job request, only looked at while idle
//   cfg_layers_i   : number of layers L (1..4)
//   cfg_k_i        : MAC beats per output K (1..63)
//   cfg_n_i        : outputs per layer N (1..63)
//   w_addr_o/w_en_o            : weight BRAM read port
//   act_addr_o/act_en_o        : activation read port
//   act_sel_o                  : 0 = input BRAM, 1 = temp buffer
//   tmp_rd_bank_o/tmp_wr_bank_o: ping-pong bank selects
//   tmp_wr_addr_o/tmp_wr_en_o  : temp buffer write port
//   pu_en_o/pu_valid_o/pu_clear_o : processing-unit controls
//   busy_o/done_o/err_o        : status
//
// All outputs come straight from flops. They are computed from the next-state
// values so that they line up with the state they belong to.
// -----------------------------------------------------------------------------
module layer_sequencer #(
    parameter int DW  = 6,
    parameter int WAW = 14
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic [2:0]     cfg_layers_i,
    input  logic [DW-1:0]  cfg_k_i,
    input  logic [DW-1:0]  cfg_n_i,
    output logic [WAW-1:0] w_addr_o,
    output logic           w_en_o,
    output logic [DW-1:0]  act_addr_o,
    output logic           act_en_o,
    output logic           act_sel_o,
    output logic           tmp_rd_bank_o,
    output logic           tmp_wr_bank_o,
    output logic [DW-1:0]  tmp_wr_addr_o,
    output logic           tmp_wr_en_o,
    output logic           pu_en_o,
    output logic           pu_valid_o,
    output logic           pu_clear_o,
    output logic           busy_o,
    output logic           done_o,
    output logic           err_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_TAIL  = 3'd2,
        ST_WB    = 3'd3,
        ST_CLR   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    localparam logic [DW-1:0]  DW_ZERO  = {DW{1'b0}};
    localparam logic [DW-1:0]  DW_ONE   = {{(DW-1){1'b0}}, 1'b1};
    localparam logic [WAW-1:0] WAW_ZERO = {WAW{1'b0}};
    localparam logic [WAW-1:0] WAW_ONE  = {{(WAW-1){1'b0}}, 1'b1};

    // Control state
    state_t         state_r, state_nxt_s;
    logic [DW-1:0]  beat_r, beat_nxt_s;     // beat index within the current output
    logic [DW-1:0]  out_r, out_nxt_s;       // output index n within the layer
    logic [1:0]     layer_r, layer_nxt_s;   // layer index j
    logic [WAW-1:0] waddr_r, waddr_nxt_s;   // running weight address, never rewinds mid-job
    logic [2:0]     cfg_l_r, cfg_l_nxt_s;
    logic [DW-1:0]  cfg_k_r, cfg_k_nxt_s;
    logic [DW-1:0]  cfg_n_r, cfg_n_nxt_s;
    logic           err_r, err_nxt_s;

    // Decode helpers
    logic cfg_legal_s;
    logic last_beat_s;
    logic last_out_s;
    logic last_layer_s;

    // Next-cycle output values
    logic [WAW-1:0] w_addr_s;
    logic           w_en_s;
    logic [DW-1:0]  act_addr_s;
    logic           active_s;
    logic           act_sel_s;
    logic           rd_bank_s;
    logic           wr_bank_s;
    logic [DW-1:0]  tmp_wr_addr_s;
    logic           wb_s;
    logic           clr_s;
    logic           busy_s;
    logic           done_s;

    // Output flops
    logic [WAW-1:0] w_addr_r;
    logic           w_en_r;
    logic [DW-1:0]  act_addr_r;
    logic           act_en_r;
    logic           act_sel_r;
    logic           rd_bank_r;
    logic           wr_bank_r;
    logic [DW-1:0]  tmp_wr_addr_r;
    logic           tmp_wr_en_r;
    logic           pu_en_r;
    logic           pu_valid_r;
    logic           pu_clear_r;
    logic           busy_r;
    logic           done_r;

    // Legality of the requested configuration and end-of-loop flags.
    always_comb begin
        cfg_legal_s = (cfg_layers_i != 3'd0) && (cfg_layers_i <= 3'd4) &&
                      (cfg_k_i != DW_ZERO) && (cfg_n_i != DW_ZERO) &&
                      ((cfg_layers_i == 3'd1) || (cfg_k_i == cfg_n_i));
        last_beat_s  = (beat_r == (cfg_k_r - DW_ONE));
        last_out_s   = (out_r == (cfg_n_r - DW_ONE));
        last_layer_s = ({1'b0, layer_r} == (cfg_l_r - 3'd1));
    end

    // Next-state and counter update logic.
    always_comb begin
        state_nxt_s = state_r;
        beat_nxt_s  = beat_r;
        out_nxt_s   = out_r;
        layer_nxt_s = layer_r;
        waddr_nxt_s = waddr_r;
        cfg_l_nxt_s = cfg_l_r;
        cfg_k_nxt_s = cfg_k_r;
        cfg_n_nxt_s = cfg_n_r;
        err_nxt_s   = err_r;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    cfg_l_nxt_s = cfg_layers_i;
                    cfg_k_nxt_s = cfg_k_i;
                    cfg_n_nxt_s = cfg_n_i;
                    err_nxt_s   = ~cfg_legal_s;
                    beat_nxt_s  = DW_ZERO;
                    out_nxt_s   = DW_ZERO;
                    layer_nxt_s = 2'd0;
                    waddr_nxt_s = WAW_ZERO;
                    state_nxt_s = cfg_legal_s ? ST_FETCH : ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_FETCH: begin
                waddr_nxt_s = waddr_r + WAW_ONE;
                if (last_beat_s) begin
                    beat_nxt_s  = DW_ZERO;
                    state_nxt_s = ST_TAIL;
                end else begin
                    beat_nxt_s  = beat_r + DW_ONE;
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_TAIL: begin
                state_nxt_s = ST_WB;
            end
            ST_WB: begin
                state_nxt_s = ST_CLR;
            end
            ST_CLR: begin
                if (last_out_s) begin
                    out_nxt_s = DW_ZERO;
                    if (last_layer_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        // Moving to the next layer flips both ping-pong banks.
                        layer_nxt_s = layer_r + 2'd1;
                        state_nxt_s = ST_FETCH;
                    end
                end else begin
                    out_nxt_s   = out_r + DW_ONE;
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, decoded from the next state.
    always_comb begin
        w_en_s        = (state_nxt_s == ST_FETCH);
        wb_s          = (state_nxt_s == ST_WB);
        clr_s         = (state_nxt_s == ST_CLR);
        done_s        = (state_nxt_s == ST_DONE);
        busy_s        = (state_nxt_s != ST_IDLE);
        active_s      = (state_nxt_s == ST_FETCH) || (state_nxt_s == ST_TAIL) ||
                        wb_s || clr_s;
        w_addr_s      = w_en_s ? waddr_nxt_s : WAW_ZERO;
        act_addr_s    = w_en_s ? beat_nxt_s : DW_ZERO;
        tmp_wr_addr_s = wb_s ? out_nxt_s : DW_ZERO;
        act_sel_s     = active_s && (layer_nxt_s != 2'd0);
        // Layer j writes bank j[0] and reads bank (j-1)[0], i.e. the opposite one.
        wr_bank_s     = active_s && layer_nxt_s[0];
        rd_bank_s     = active_s && !layer_nxt_s[0];
    end

    // Control state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            beat_r  <= DW_ZERO;
            out_r   <= DW_ZERO;
            layer_r <= 2'd0;
            waddr_r <= WAW_ZERO;
            cfg_l_r <= 3'd0;
            cfg_k_r <= DW_ZERO;
            cfg_n_r <= DW_ZERO;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            beat_r  <= beat_nxt_s;
            out_r   <= out_nxt_s;
            layer_r <= layer_nxt_s;
            waddr_r <= waddr_nxt_s;
            cfg_l_r <= cfg_l_nxt_s;
            cfg_k_r <= cfg_k_nxt_s;
            cfg_n_r <= cfg_n_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    // Output registers; pu_en trails w_en by one cycle to match the BRAM latency.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            w_addr_r      <= WAW_ZERO;
            w_en_r        <= 1'b0;
            act_addr_r    <= DW_ZERO;
            act_en_r      <= 1'b0;
            act_sel_r     <= 1'b0;
            rd_bank_r     <= 1'b0;
            wr_bank_r     <= 1'b0;
            tmp_wr_addr_r <= DW_ZERO;
            tmp_wr_en_r   <= 1'b0;
            pu_en_r       <= 1'b0;
            pu_valid_r    <= 1'b0;
            pu_clear_r    <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            w_addr_r      <= w_addr_s;
            w_en_r        <= w_en_s;
            act_addr_r    <= act_addr_s;
            act_en_r      <= w_en_s;
            act_sel_r     <= act_sel_s;
            rd_bank_r     <= rd_bank_s;
            wr_bank_r     <= wr_bank_s;
            tmp_wr_addr_r <= tmp_wr_addr_s;
            tmp_wr_en_r   <= wb_s;
            pu_en_r       <= w_en_r;
            pu_valid_r    <= wb_s;
            pu_clear_r    <= clr_s;
            busy_r        <= busy_s;
            done_r        <= done_s;
        end
    end

    assign w_addr_o      = w_addr_r;
    assign w_en_o        = w_en_r;
    assign act_addr_o    = act_addr_r;
    assign act_en_o      = act_en_r;
    assign act_sel_o     = act_sel_r;
    assign tmp_rd_bank_o = rd_bank_r;
    assign tmp_wr_bank_o = wr_bank_r;
    assign tmp_wr_addr_o = tmp_wr_addr_r;
    assign tmp_wr_en_o   = tmp_wr_en_r;
    assign pu_en_o       = pu_en_r;
    assign pu_valid_o    = pu_valid_r;
    assign pu_clear_o    = pu_clear_r;
    assign busy_o        = busy_r;
    assign done_o        = done_r;
    assign err_o         = err_r;

endmodule

// File: tb/tb_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_layer_sequencer
//
// Self-checking bench for layer_sequencer. A reference model expands each job
// into the full per-cycle list of expected output values (nested loops over
// layers, outputs and beats) and every DUT cycle is compared against it.
// -----------------------------------------------------------------------------
module tb_layer_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [2:0]  cfg_layers_i;
    logic [5:0]  cfg_k_i;
    logic [5:0]  cfg_n_i;
    logic [13:0] w_addr_o;
    logic        w_en_o;
    logic [5:0]  act_addr_o;
    logic        act_en_o;
    logic        act_sel_o;
    logic        tmp_rd_bank_o;
    logic        tmp_wr_bank_o;
    logic [5:0]  tmp_wr_addr_o;
    logic        tmp_wr_en_o;
    logic        pu_en_o;
    logic        pu_valid_o;
    logic        pu_clear_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int n_vec = 0;
    int n_err = 0;
    int job_id = 0;
    logic [37:0] exp_q[$];

    layer_sequencer #(.DW(6), .WAW(14)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .cfg_layers_i  (cfg_layers_i),
        .cfg_k_i       (cfg_k_i),
        .cfg_n_i       (cfg_n_i),
        .w_addr_o      (w_addr_o),
        .w_en_o        (w_en_o),
        .act_addr_o    (act_addr_o),
        .act_en_o      (act_en_o),
        .act_sel_o     (act_sel_o),
        .tmp_rd_bank_o (tmp_rd_bank_o),
        .tmp_wr_bank_o (tmp_wr_bank_o),
        .tmp_wr_addr_o (tmp_wr_addr_o),
        .tmp_wr_en_o   (tmp_wr_en_o),
        .pu_en_o       (pu_en_o),
        .pu_valid_o    (pu_valid_o),
        .pu_clear_o    (pu_clear_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o)
    );

    // Free-running clock.
    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [37:0] got, input logic [37:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Pack one cycle's outputs: waddr, wen, aaddr, aen, asel, rdb, wrb, twa, twe, pue, puv, puc, busy, done, err.
    function automatic logic [37:0] mk(input int waddr, input int aaddr, input int twa,
                                       input bit wen, input bit asel, input bit rdb, input bit wrb,
                                       input bit wb, input bit pue, input bit puc,
                                       input bit busy, input bit done, input bit err);
        logic [13:0] wa;
        logic [5:0]  aa;
        logic [5:0]  ta;
        wa = 14'(waddr);
        aa = 6'(aaddr);
        ta = 6'(twa);
        return {wa, wen, aa, wen, asel, rdb, wrb, ta, wb, pue, wb, puc, busy, done, err};
    endfunction

    function automatic logic [37:0] sample();
        return {w_addr_o, w_en_o, act_addr_o, act_en_o, act_sel_o, tmp_rd_bank_o, tmp_wr_bank_o,
                tmp_wr_addr_o, tmp_wr_en_o, pu_en_o, pu_valid_o, pu_clear_o, busy_o, done_o, err_o};
    endfunction

    // Expected trace, starting with the cycle after start_i is accepted and ending in IDLE.
    task automatic build_trace(input int L, input int K, input int N);
        bit legal;
        int addr;
        bit sel, rdb, wrb;
        exp_q.delete();
        legal = (L >= 1) && (L <= 4) && (K >= 1) && (N >= 1) && ((L == 1) || (K == N));
        if (!legal) begin
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        end else begin
            addr = 0;
            for (int j = 0; j < L; j++) begin
                sel = (j > 0);
                wrb = bit'(j % 2);
                rdb = bit'((j + 1) % 2);
                for (int n = 0; n < N; n++) begin
                    for (int k = 0; k < K; k++) begin
                        exp_q.push_back(mk(addr, k, 0, 1, sel, rdb, wrb, 0, (k > 0), 0, 1, 0, 0));
                        addr++;
                    end
                    exp_q.push_back(mk(0, 0, 0, 0, sel, rdb, wrb, 0, 1, 0, 1, 0, 0));
                    exp_q.push_back(mk(0, 0, n, 0, sel, rdb, wrb, 1, 0, 0, 1, 0, 0));
                    exp_q.push_back(mk(0, 0, 0, 0, sel, rdb, wrb, 0, 0, 1, 1, 0, 0));
                end
            end
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
    endtask

    // Async reset in the middle of a cycle, then one idle cycle after release.
    task automatic do_reset_check();
        rst_i   = 1'b1;
        start_i = 1'b0;
        #1;
        check_val("async_reset", sample(), 38'd0);
        #2;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        check_val("idle_after_reset", sample(), 38'd0);
    endtask

    // Run one job from an IDLE cycle; leaves the bench in the final IDLE cycle.
    task automatic run_job(input int L, input int K, input int N, input bit hold,
                           input bit noise, input int abort_idx);
        int sz;
        job_id++;
        build_trace(L, K, N);
        sz = exp_q.size();
        start_i      = 1'b1;
        cfg_layers_i = 3'(L);
        cfg_k_i      = 6'(K);
        cfg_n_i      = 6'(N);
        @(posedge clk_i);
        #1;
        if (!hold) start_i = 1'b0;
        for (int i = 0; i < sz; i++) begin
            check_val($sformatf("job%0d L%0d K%0d N%0d cyc%0d", job_id, L, K, N, i), sample(), exp_q[i]);
            if (i == abort_idx) begin
                do_reset_check();
                return;
            end
            if (noise) begin
                cfg_layers_i = 3'($urandom_range(0, 7));
                cfg_k_i      = 6'($urandom_range(0, 63));
                cfg_n_i      = 6'($urandom_range(0, 63));
                if (!hold) start_i = (i < sz - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            if (i != sz - 1) begin
                @(posedge clk_i);
                #1;
            end
        end
    endtask

    initial begin
        int L, K, N;
        rst_i        = 1'b1;
        start_i      = 1'b0;
        cfg_layers_i = 3'd0;
        cfg_k_i      = 6'd0;
        cfg_n_i      = 6'd0;
        #1;
        check_val("reset_state", sample(), 38'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        check_val("idle_after_release", sample(), 38'd0);

        run_job(1, 4, 2, 0, 0, -1);
        run_job(2, 3, 3, 0, 0, -1);
        run_job(2, 3, 4, 0, 0, -1);
        repeat (3) begin
            @(posedge clk_i);
            #1;
            check_val("err_sticky", sample(), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        end
        run_job(4, 1, 1, 0, 0, -1);
        run_job(0, 3, 3, 0, 0, -1);
        run_job(5, 3, 3, 0, 0, -1);
        run_job(1, 0, 4, 0, 0, -1);
        run_job(1, 4, 0, 0, 0, -1);
        run_job(1, 5, 2, 0, 0, -1);

        // start held high with cfg churning, then a back-to-back second job
        run_job(2, 2, 2, 1, 1, -1);
        run_job(1, 3, 5, 0, 0, -1);

        // reset during the first WB of layer 1, then a fresh job from address 0
        run_job(2, 3, 3, 0, 0, 22);
        run_job(1, 2, 3, 0, 0, -1);

        run_job(1, 63, 63, 0, 0, -1);
        run_job(4, 63, 63, 0, 0, -1);

        for (int r = 0; r < 25; r++) begin
            L = $urandom_range(0, 5);
            K = $urandom_range(0, 10);
            N = ((L > 1) && ($urandom_range(0, 3) != 0)) ? K : $urandom_range(0, 10);
            run_job(L, K, N, 0, 1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
